// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: op encodings, FSM states and
// instruction field positions, plus small field-extraction helpers.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int OP_W    = 6;
  localparam int IMM_W   = 16;

  localparam logic [OP_W-1:0] OP_ADD = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB = 6'd1;
  localparam logic [OP_W-1:0] OP_MUL = 6'd2;
  localparam logic [OP_W-1:0] OP_NOT = 6'd3;
  localparam logic [OP_W-1:0] OP_LI  = 6'd4;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RA_MSB  = 20;
  localparam int RA_LSB  = 16;
  localparam int RB_MSB  = 15;
  localparam int RB_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  function automatic logic [OP_W-1:0] instr_op(input logic [XLEN-1:0] w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [RADDR_W-1:0] instr_rd(input logic [XLEN-1:0] w);
    return w[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [RADDR_W-1:0] instr_ra(input logic [XLEN-1:0] w);
    return w[RA_MSB:RA_LSB];
  endfunction

  function automatic logic [RADDR_W-1:0] instr_rb(input logic [XLEN-1:0] w);
    return w[RB_MSB:RB_LSB];
  endfunction

  function automatic logic [IMM_W-1:0] instr_imm(input logic [XLEN-1:0] w);
    return w[IMM_MSB:IMM_LSB];
  endfunction

  // Register-to-register ops that are forwarded to the external ALU verbatim.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_NOT};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU sequencer: one write port, two operand read
// ports and one debug read port; R0 always reads as zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [RADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]    wr_data,
  input  logic [RADDR_W-1:0] rd_addr_a,
  output logic [XLEN-1:0]    rd_data_a,
  input  logic [RADDR_W-1:0] rd_addr_b,
  output logic [XLEN-1:0]    rd_data_b,
  input  logic [RADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]    dbg_data
);

  logic [XLEN-1:0] mem_q [NREG];

  // Addresses at or beyond NREG behave like R0: read zero, writes dropped.
  function automatic logic backed(input logic [RADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NREG);
  endfunction

  // NOTE: the whole array is reset because a reset must leave every register
  // reading zero; this rules out an SRAM macro and keeps it in flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && backed(wr_addr)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = backed(rd_addr_a) ? mem_q[rd_addr_a] : '0;
  assign rd_data_b = backed(rd_addr_b) ? mem_q[rd_addr_b] : '0;
  assign dbg_data  = backed(dbg_addr)  ? mem_q[dbg_addr]  : '0;

endmodule

// File: rtl/alu_sequencer.sv
// Four-state sequencer that fetches one instruction, drives an external
// combinational ALU with registered operands and writes the result back.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [OP_W-1:0]    alu_opcode,
  output logic [XLEN-1:0]    alu_rs1,
  output logic [XLEN-1:0]    alu_rs2,
  input  logic [XLEN-1:0]    alu_result,
  output logic               done,
  output logic [RADDR_W-1:0] done_rd,
  output logic [XLEN-1:0]    done_data,
  output logic               illegal,
  input  logic [RADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]    dbg_data
);

  state_t          state_q,   state_d;
  logic [XLEN-1:0] instr_q,   instr_d;
  logic [OP_W-1:0] opcode_q,  opcode_d;
  logic [XLEN-1:0] rs1_q,     rs1_d;
  logic [XLEN-1:0] rs2_q,     rs2_d;
  logic [XLEN-1:0] result_q,  result_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] rf_data_a;
  logic [XLEN-1:0] rf_data_b;
  logic            rf_wr_en;
  logic [OP_W-1:0] cur_op;

  assign cur_op = instr_op(instr_q);

  // NOTE: every next-state signal takes its current value first, so paths
  // that do not assign it cannot infer a latch.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    opcode_d  = opcode_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    result_d  = result_q;
    illegal_d = illegal_q;

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu_op(cur_op)) begin
          opcode_d  = cur_op;
          rs1_d     = rf_data_a;
          rs2_d     = rf_data_b;
          illegal_d = 1'b0;
        end else if (cur_op == OP_LI) begin
          opcode_d  = OP_ADD;
          rs1_d     = '0;
          rs2_d     = {{(XLEN-IMM_W){1'b0}}, instr_imm(instr_q)};
          illegal_d = 1'b0;
        end else begin
          // Unsupported op: leave the ALU operands untouched.
          illegal_d = 1'b1;
        end
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        result_d = illegal_q ? '0 : alu_result;
        state_d  = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      opcode_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      opcode_q  <= opcode_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign rf_wr_en = (state_q == ST_WRITEBACK) && !illegal_q;

  alu_regfile #(
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (rf_wr_en),
    .wr_addr   (instr_rd(instr_q)),
    .wr_data   (result_q),
    .rd_addr_a (instr_ra(instr_q)),
    .rd_data_a (rf_data_a),
    .rd_addr_b (instr_rb(instr_q)),
    .rd_data_b (rf_data_b),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_opcode  = opcode_q;
  assign alu_rs1     = rs1_q;
  assign alu_rs2     = rs2_q;
  assign done        = (state_q == ST_WRITEBACK);
  assign illegal     = done && illegal_q;
  assign done_rd     = instr_rd(instr_q);
  assign done_data   = result_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed programs, random programs,
// back-to-back streaming and reset abort, against a behavioural model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [31:0] alu_result;
  logic        done;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model state.
  logic [31:0] ref_r [32];
  logic [5:0]  ref_opcode;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ill;
  } exp_t;

  always #5 clk = ~clk;

  // The external combinational ALU that the sequencer drives.
  function automatic logic [31:0] ext_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a * b;
      6'd3:    return ~a;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_result = ext_alu(alu_opcode, alu_rs1, alu_rs2);

  alu_sequencer #(.NREG(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_opcode  (alu_opcode),
    .alu_rs1     (alu_rs1),
    .alu_rs2     (alu_rs2),
    .alu_result  (alu_result),
    .done        (done),
    .done_rd     (done_rd),
    .done_data   (done_data),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 11'd0};
  endfunction

  function automatic logic [31:0] enc_li(input logic [4:0] rd, input logic [15:0] imm);
    return {6'd4, rd, 5'd0, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_r[i] = 32'h0;
    ref_opcode = 6'd0;
  endtask

  // Architectural effect of one instruction; R0 is never written so reads of it give 0.
  task automatic model_exec(input logic [31:0] w, output logic [31:0] data, output logic ill);
    logic [5:0]  op;
    logic [4:0]  rd, ra, rb;
    op = w[31:26];
    rd = w[25:21];
    ra = w[20:16];
    rb = w[15:11];
    ill = 1'b0;
    case (op)
      6'd0: begin data = ref_r[ra] + ref_r[rb]; ref_opcode = op; end
      6'd1: begin data = ref_r[ra] - ref_r[rb]; ref_opcode = op; end
      6'd2: begin data = ref_r[ra] * ref_r[rb]; ref_opcode = op; end
      6'd3: begin data = ~ref_r[ra];            ref_opcode = op; end
      6'd4: begin data = {16'h0, w[15:0]};      ref_opcode = 6'd0; end
      default: begin data = 32'h0; ill = 1'b1; end
    endcase
    if (!ill && rd != 5'd0) ref_r[rd] = data;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
    dbg_addr = r;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // One instruction through the full T..T+4 window, with a junk word held
  // valid while busy to show it is ignored.
  task automatic run_instr(input logic [31:0] w);
    logic [31:0] exp_data;
    logic        exp_ill;
    int          n;
    @(negedge clk);
    instr       = w;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", instr_ready, 1);
    @(negedge clk);
    model_exec(w, exp_data, exp_ill);
    instr = $urandom;
    check("decode_done", done, 0);
    check("decode_ready", instr_ready, 0);
    @(negedge clk);
    check("execute_done", done, 0);
    check("execute_opcode", alu_opcode, ref_opcode);
    @(negedge clk);
    instr_valid = 1'b0;
    check("wb_done", done, 1);
    check("wb_done_rd", done_rd, w[25:21]);
    check("wb_done_data", done_data, exp_data);
    check("wb_illegal", illegal, exp_ill);
    @(negedge clk);
    check("next_done", done, 0);
    check("next_ready", instr_ready, 1);
    check_reg("dbg_rd", w[25:21], ref_r[w[25:21]]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    int sel;
    sel = $urandom_range(0, 7);
    op  = (sel >= 5) ? 6'($urandom_range(5, 63)) : 6'(sel);
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 11'($urandom)};
  endfunction

  // instr_valid held high: one accept every 4 cycles, dones in program order.
  task automatic stream_test(input int n_instr);
    logic [31:0] prog [$];
    exp_t        exp_q [$];
    exp_t        e;
    int          idx;
    int          last_acc;
    int          dones;
    for (int i = 0; i < n_instr; i++) prog.push_back(rand_instr());
    idx      = 0;
    last_acc = -100;
    dones    = 0;
    for (int c = 0; c < n_instr * 4 + 12; c++) begin
      @(negedge clk);
      instr_valid = (idx < n_instr);
      instr       = (idx < n_instr) ? prog[idx] : $urandom;
      check("stream_done", done, (c - last_acc == 3) ? 1 : 0);
      if (done) begin
        dones++;
        check("stream_exp_avail", exp_q.size() > 0 ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("stream_rd", done_rd, e.rd);
          check("stream_data", done_data, e.data);
          check("stream_illegal", illegal, e.ill);
        end
      end
      check("stream_ready", instr_ready, (c - last_acc >= 4) ? 1 : 0);
      if (instr_ready && instr_valid) begin
        model_exec(prog[idx], e.data, e.ill);
        e.rd = prog[idx][25:21];
        exp_q.push_back(e);
        last_acc = c;
        idx++;
      end
    end
    instr_valid = 1'b0;
    check("stream_accepts", idx, n_instr);
    check("stream_dones", dones, n_instr);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    rst         = 1'b1;
    instr       = 32'h0;
    instr_valid = 1'b0;
    dbg_addr    = 5'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_rs1", alu_rs1, 0);
    check("rst_rs2", alu_rs2, 0);
    check("rst_done_data", done_data, 0);
    for (int r = 0; r < 32; r += 5) check_reg("rst_reg", 5'(r), 32'h0);

    run_instr(enc_li(5'd1, 16'h1234));
    check_reg("li_r1", 5'd1, 32'h0000_1234);

    run_instr(enc_li(5'd1, 16'd5));
    run_instr(enc_li(5'd2, 16'd7));
    run_instr(enc(6'd1, 5'd3, 5'd1, 5'd2));
    check_reg("sub_wrap_r3", 5'd3, 32'hFFFF_FFFE);

    run_instr(enc_li(5'd4, 16'h1000));
    run_instr(enc(6'd2, 5'd5, 5'd4, 5'd4));
    check_reg("mul_r5", 5'd5, 32'h0100_0000);
    run_instr(enc(6'd3, 5'd6, 5'd0, 5'd0));
    check_reg("not_r6", 5'd6, 32'hFFFF_FFFF);

    run_instr(enc(6'h3F, 5'd7, 5'd1, 5'd2));
    check_reg("illegal_r7", 5'd7, 32'h0);
    check("illegal_keeps_opcode", alu_opcode, 6'd3);

    run_instr(enc(6'd0, 5'd0, 5'd1, 5'd2));
    check_reg("r0_zero", 5'd0, 32'h0);
    run_instr(enc(6'd0, 5'd1, 5'd1, 5'd1));
    check_reg("same_reg_r1", 5'd1, 32'd10);

    for (int i = 0; i < 40; i++) run_instr(rand_instr());

    stream_test(12);

    for (int r = 0; r < 32; r++) check_reg("final_reg", 5'(r), ref_r[r]);

    // Reset during EXECUTE of ADD r8 aborts it.
    run_instr(enc_li(5'd9, 16'd3));
    @(negedge clk);
    instr       = enc(6'd0, 5'd8, 5'd9, 5'd9);
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("abort_accept_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort_no_done", done, 0);
    @(negedge clk);
    check("abort_ready_after", instr_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("abort_quiet", done, 0);
      @(negedge clk);
    end
    check("abort_opcode", alu_opcode, 0);
    check("abort_rs2", alu_rs2, 0);
    check_reg("abort_r8", 5'd8, 32'h0);
    check_reg("abort_r9", 5'd9, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
